// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pkg
//  Brief    : Shared types, widths and helpers for the servo controller stages
//  Revision : 1.0
// ============================================================================
package servo_pkg;

  localparam int DATA_W = 18;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } pwm_state_t;

  // |v| >> shift, clamped to limit; the most negative value cannot be negated
  // in DATA_W bits, so it saturates directly to limit.
  function automatic logic [DATA_W-1:0] sat_abs_shift(
    input logic signed [DATA_W-1:0] v,
    input int unsigned              shift,
    input logic        [DATA_W-1:0] limit
  );
    logic [DATA_W-1:0] mag;
    if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
      mag = limit;
    end else begin
      mag = v[DATA_W-1] ? (~v + 1'b1) : v;
      mag = mag >> shift;
      if (mag > limit) begin
        mag = limit;
      end
    end
    return mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_timebase
//  Brief    : PWM period counter, period boundary flag and sample_tick divider
//  Revision : 1.0
// ============================================================================
module pwm_timebase #(
  parameter int CNT_W      = 10,
  parameter int PERIOD     = 1000,
  parameter int SAMPLE_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt_o,
  output logic             boundary_o,
  output logic             sample_tick_o
);

  localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  assign boundary_o = (cnt_q == LAST_CNT);

  // The tick is precomputed from next-state so the registered pulse lands
  // exactly on the boundary cycle of every SAMPLE_DIV-th period.
  always_comb begin
    cnt_d = boundary_o ? '0 : cnt_q + 1'b1;
    div_d = div_q;
    if (boundary_o) begin
      div_d = (div_q == LAST_DIV) ? '0 : div_q + 1'b1;
    end
    tick_d = (cnt_d == LAST_CNT) && (div_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign sample_tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/ipd_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ipd_pwm_driver
//  Brief    : Signed IPD command to two-leg H-bridge PWM with dead time
//  Revision : 1.0
// ============================================================================
module ipd_pwm_driver
  import servo_pkg::*;
#(
  parameter int          CNT_W      = 10,
  parameter int          PERIOD     = 1000,
  parameter int unsigned SHIFT      = 7,
  parameter int          DEAD_CYC   = 8,
  parameter int          SAMPLE_DIV = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] ipd,
  output logic                     sample_tick,
  output logic                     pwm_a,
  output logic                     pwm_b,
  output logic                     dir
);

  localparam logic [DATA_W-1:0] DUTY_MAX  = DATA_W'(PERIOD);
  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

  logic [CNT_W-1:0]  cnt;
  logic              boundary;

  pwm_timebase #(
    .CNT_W      (CNT_W),
    .PERIOD     (PERIOD),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .cnt_o         (cnt),
    .boundary_o    (boundary),
    .sample_tick_o (sample_tick)
  );

  pwm_state_t        state_q;
  logic              dir_q;
  logic [DATA_W-1:0] active_duty_q;
  logic              pend_valid_q;
  logic [DATA_W-1:0] pend_duty_q;
  logic              pend_dir_q;
  logic              pwm_a_q, pwm_b_q;

  logic [DATA_W-1:0] cap_duty_d;
  logic              cap_dir_d;
  logic              on_d;

  // A zero command carries no direction, so it keeps the bridge where it is.
  always_comb begin
    cap_duty_d = sat_abs_shift(ipd, SHIFT, DUTY_MAX);
    cap_dir_d  = (cap_duty_d == '0) ? dir_q : ipd[DATA_W-1];
    on_d       = (state_q == ST_RUN) && (DATA_W'(cnt) < active_duty_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      dir_q         <= 1'b0;
      active_duty_q <= '0;
      pend_valid_q  <= 1'b0;
      pend_duty_q   <= '0;
      pend_dir_q    <= 1'b0;
      pwm_a_q       <= 1'b0;
      pwm_b_q       <= 1'b0;
    end else begin
      if ((state_q == ST_DEAD) && (cnt == DEAD_LAST)) begin
        state_q <= ST_RUN;
      end
      if (boundary && pend_valid_q) begin
        active_duty_q <= pend_duty_q;
        pend_valid_q  <= 1'b0;
        if (pend_dir_q != dir_q) begin
          dir_q <= pend_dir_q;
          if (DEAD_CYC > 0) begin
            state_q <= ST_DEAD;
          end
        end
      end
      // Placed after the boundary update so a same-edge capture stays pending.
      if (enable) begin
        pend_duty_q  <= cap_duty_d;
        pend_dir_q   <= cap_dir_d;
        pend_valid_q <= 1'b1;
      end
      pwm_a_q <= on_d & ~dir_q;
      pwm_b_q <= on_d &  dir_q;
    end
  end

  assign pwm_a = pwm_a_q;
  assign pwm_b = pwm_b_q;
  assign dir   = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_ipd_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ipd_pwm_driver
//  Brief    : Self-checking bench for ipd_pwm_driver with a per-period model
//  Revision : 1.0
// ============================================================================
module tb_ipd_pwm_driver;
  import servo_pkg::*;

  localparam int P    = 1000;
  localparam int SH   = 7;
  localparam int DEAD = 8;

  logic                     clk    = 1'b0;
  logic                     reset  = 1'b0;
  logic                     enable = 1'b0;
  logic signed [DATA_W-1:0] ipd    = '0;
  logic st1, a1, b1, d1;
  logic st4, a4, b4, d4;

  always #5 clk = ~clk;

  ipd_pwm_driver #(.CNT_W(10), .PERIOD(P), .SHIFT(SH), .DEAD_CYC(DEAD), .SAMPLE_DIV(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ipd(ipd),
    .sample_tick(st1), .pwm_a(a1), .pwm_b(b1), .dir(d1)
  );

  ipd_pwm_driver #(.CNT_W(10), .PERIOD(P), .SHIFT(SH), .DEAD_CYC(DEAD), .SAMPLE_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .ipd(ipd),
    .sample_tick(st4), .pwm_a(a4), .pwm_b(b4), .dir(d4)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: each period's command is decided by the last capture aimed at it.
  int cmd_duty [0:127];
  bit cmd_dir  [0:127];
  bit cmd_v    [0:127];
  int e;
  int m_duty;
  bit m_dir;
  bit m_dead;
  int ca, cb, fa, fb, la, lb;

  function automatic int conv_duty(input logic signed [DATA_W-1:0] v);
    int iv;
    iv = int'(v);
    if (iv < 0) iv = -iv;
    iv = iv / (1 << SH);
    return (iv > P) ? P : iv;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 128; i++) begin
      cmd_v[i] = 1'b0; cmd_duty[i] = 0; cmd_dir[i] = 1'b0;
    end
    e = 0; m_duty = 0; m_dir = 1'b0; m_dead = 1'b0;
    ca = 0; cb = 0; fa = -1; fb = -1; la = -1; lb = -1;
  endtask

  task automatic period_eval();
    int exp_cnt, exp_first, act_cnt, oth_cnt, act_first, act_last;
    exp_cnt   = m_dead ? ((m_duty > DEAD) ? m_duty - DEAD : 0) : m_duty;
    exp_first = m_dead ? DEAD : 0;
    act_cnt   = m_dir ? cb : ca;
    oth_cnt   = m_dir ? ca : cb;
    act_first = m_dir ? fb : fa;
    act_last  = m_dir ? lb : la;
    chk("period_high_count", act_cnt, exp_cnt);
    chk("period_other_leg", oth_cnt, 0);
    if (exp_cnt > 0) begin
      chk("period_first_high", act_first, exp_first);
      chk("period_last_high", act_last, exp_first + exp_cnt - 1);
    end
  endtask

  task automatic observe(input bit r, input bit en, input logic signed [DATA_W-1:0] v);
    int pos, n, tgt, dty;
    if (!r) begin
      chk("rst_pwm_a", a1, 0);
      chk("rst_pwm_b", b1, 0);
      chk("rst_dir", d1, 0);
      chk("rst_tick", st1, 0);
      chk("rst_tick4", st4, 0);
      chk("rst_cnt", 32'(dut.u_timebase.cnt_q), 0);
      model_clear();
      return;
    end
    e++;
    pos = (e - 1) % P;
    n   = (e - 1) / P;
    chk("excl_ab", a1 & b1, 0);
    chk("excl_ab4", a4 & b4, 0);
    chk("tick_div1", st1, (e % P) == P - 1);
    chk("tick_div4", st4, ((e % P) == P - 1) && (((e / P) % 4) == 0));
    if (pos == 0) begin
      if (cmd_v[n]) begin
        m_dead = (cmd_dir[n] != m_dir);
        m_duty = cmd_duty[n];
        m_dir  = cmd_dir[n];
      end else begin
        m_dead = 1'b0;
      end
      chk("dir", d1, m_dir);
      ca = 0; cb = 0; fa = -1; fb = -1; la = -1; lb = -1;
    end
    if (a1 === 1'b1) begin if (fa < 0) fa = pos; la = pos; ca++; end
    if (b1 === 1'b1) begin if (fb < 0) fb = pos; lb = pos; cb++; end
    if (en) begin
      tgt = e / P + 1;
      dty = conv_duty(v);
      cmd_duty[tgt] = dty;
      cmd_dir[tgt]  = (dty == 0) ? m_dir : (v < 0);
      cmd_v[tgt]    = 1'b1;
    end
    if (pos == P - 1) period_eval();
  endtask

  task automatic cyc(input bit r, input bit en, input logic signed [DATA_W-1:0] v);
    reset = r; enable = en; ipd = v;
    @(posedge clk);
    @(negedge clk);
    observe(r, en, v);
    enable = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, DATA_W'($urandom));
  endtask

  task automatic run_to(input int p);
    while ((e % P) != p) idle();
  endtask

  // Finish the current period, then k-1 more whole periods.
  task automatic periods(input int k);
    idle();
    run_to(0);
    repeat (k - 1) repeat (P) idle();
  endtask

  task automatic cap(input logic signed [DATA_W-1:0] v);
    cyc(1'b1, 1'b1, v);
  endtask

  initial begin
    model_clear();
    // T1: reset held while enable toggles
    for (int i = 0; i < 5; i++) cyc(1'b0, i[0], DATA_W'($urandom));
    periods(2);
    // T2: forward duty 100
    run_to(300); cap(18'sd12800); periods(2);
    // T3: reverse duty 200 with dead time
    cap(-18'sd25600); periods(2);
    // T4: saturation both ways, then zero holds direction
    cap(18'h1FFFF); periods(3);
    cap(18'h20000); periods(3);
    cap(18'sd0); periods(2);
    // T5: last capture in a period wins; boundary capture waits a period
    run_to(100); cap(18'sd12800);
    run_to(500); cap(18'sd6400); periods(2);
    run_to(P - 1); cap(18'sd25600); periods(2);
    // Randomized captures at random positions
    for (int k = 0; k < 8; k++) begin
      int ncap;
      ncap = int'($urandom_range(1, 3));
      for (int j = 0; j < ncap; j++) begin
        run_to(int'($urandom_range(0, P - 1)));
        cap(DATA_W'($urandom));
      end
      periods(2);
    end
    // T6: mid-period reset with pwm_a high, then divided sample_tick
    cap(18'sd64000); periods(1);
    run_to(200);
    chk("t6_pwm_a_before_reset", a1, 1);
    cyc(1'b0, 1'b0, 18'sd0);
    periods(6);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
